// File: rtl/pipelined_addsub.sv
// Pipelined two's-complement adder/subtractor. The carry chain is split into
// STAGES segments, one per register stage, and results carry a full flag set.
module pipelined_addsub #(
    parameter int WIDTH  = 32,
    parameter int STAGES = 4,
    parameter int TAG_W  = 5
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    input  logic               op,
    input  logic [TAG_W-1:0]   in_tag,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [WIDTH-1:0]   result,
    output logic               carry,
    output logic               overflow,
    output logic               zero,
    output logic               negative,
    output logic [TAG_W-1:0]   out_tag
);

    localparam int SEG  = WIDTH / STAGES;
    localparam int LAST = STAGES - 1;

    // Per-stage registers; sum_q[k] holds the low (k+1)*SEG result bits, upper bits zero.
    logic [WIDTH-1:0] a_q   [STAGES];
    logic [WIDTH-1:0] a_d   [STAGES];
    logic [WIDTH-1:0] bx_q  [STAGES];
    logic [WIDTH-1:0] bx_d  [STAGES];
    logic [WIDTH-1:0] sum_q [STAGES];
    logic [WIDTH-1:0] sum_d [STAGES];
    logic             cy_q  [STAGES];
    logic             cy_d  [STAGES];
    logic             v_q   [STAGES];
    logic             v_d   [STAGES];
    logic [TAG_W-1:0] tag_q [STAGES];
    logic [TAG_W-1:0] tag_d [STAGES];

    logic [WIDTH-1:0] si_a   [STAGES];
    logic [WIDTH-1:0] si_bx  [STAGES];
    logic [WIDTH-1:0] si_sum [STAGES];
    logic             si_c   [STAGES];
    logic             si_v   [STAGES];
    logic [TAG_W-1:0] si_tag [STAGES];
    logic [SEG:0]     seg_sum[STAGES];

    logic ovf_q, ovf_d;
    logic zero_q, zero_d;
    logic neg_q, neg_d;
    logic adv;

    assign adv      = ~v_q[LAST] | out_ready;
    assign in_ready = adv;

    genvar gi;
    generate
        for (gi = 0; gi < STAGES; gi++) begin : g_stage
            if (gi == 0) begin : g_first
                // B is inverted once up front; op doubles as the +1 carry-in for subtraction.
                assign si_a[gi]   = a;
                assign si_bx[gi]  = op ? ~b : b;
                assign si_sum[gi] = '0;
                assign si_c[gi]   = op;
                assign si_v[gi]   = in_valid;
                assign si_tag[gi] = in_tag;
            end else begin : g_next
                assign si_a[gi]   = a_q[gi-1];
                assign si_bx[gi]  = bx_q[gi-1];
                assign si_sum[gi] = sum_q[gi-1];
                assign si_c[gi]   = cy_q[gi-1];
                assign si_v[gi]   = v_q[gi-1];
                assign si_tag[gi] = tag_q[gi-1];
            end

            assign seg_sum[gi] = {1'b0, si_a[gi][gi*SEG +: SEG]}
                               + {1'b0, si_bx[gi][gi*SEG +: SEG]}
                               + {{SEG{1'b0}}, si_c[gi]};
            assign sum_d[gi] = si_sum[gi] | (WIDTH'(seg_sum[gi][SEG-1:0]) << (gi*SEG));
            assign cy_d[gi]  = seg_sum[gi][SEG];
            assign a_d[gi]   = si_a[gi];
            assign bx_d[gi]  = si_bx[gi];
            assign v_d[gi]   = si_v[gi];
            assign tag_d[gi] = si_tag[gi];
        end
    endgenerate

    // Carry into the MSB is recovered as a^b^sum at that bit.
    always_comb begin
        ovf_d  = si_a[LAST][WIDTH-1] ^ si_bx[LAST][WIDTH-1]
               ^ sum_d[LAST][WIDTH-1] ^ cy_d[LAST];
        zero_d = (sum_d[LAST] == '0);
        neg_d  = sum_d[LAST][WIDTH-1];
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int k = 0; k < STAGES; k++) begin
                a_q[k]   <= '0;
                bx_q[k]  <= '0;
                sum_q[k] <= '0;
                cy_q[k]  <= 1'b0;
                v_q[k]   <= 1'b0;
                tag_q[k] <= '0;
            end
            ovf_q  <= 1'b0;
            zero_q <= 1'b0;
            neg_q  <= 1'b0;
        end else if (adv) begin
            for (int k = 0; k < STAGES; k++) begin
                a_q[k]   <= a_d[k];
                bx_q[k]  <= bx_d[k];
                sum_q[k] <= sum_d[k];
                cy_q[k]  <= cy_d[k];
                v_q[k]   <= v_d[k];
                tag_q[k] <= tag_d[k];
            end
            ovf_q  <= ovf_d;
            zero_q <= zero_d;
            neg_q  <= neg_d;
        end
    end

    assign out_valid = v_q[LAST];
    assign result    = sum_q[LAST];
    assign carry     = cy_q[LAST];
    assign overflow  = ovf_q;
    assign zero      = zero_q;
    assign negative  = neg_q;
    assign out_tag   = tag_q[LAST];

endmodule

// File: tb/tb_pipelined_addsub.sv
// Scoreboard bench for pipelined_addsub: accepted operations are modelled with
// plain integer arithmetic and compared in order as results are consumed.
module tb_pipelined_addsub;

    localparam int WIDTH  = 32;
    localparam int STAGES = 4;
    localparam int TAG_W  = 5;

    logic               clk;
    logic               rst_n;
    logic               in_valid;
    logic               in_ready;
    logic [WIDTH-1:0]   a;
    logic [WIDTH-1:0]   b;
    logic               op;
    logic [TAG_W-1:0]   in_tag;
    logic               out_valid;
    logic               out_ready;
    logic [WIDTH-1:0]   result;
    logic               carry;
    logic               overflow;
    logic               zero;
    logic               negative;
    logic [TAG_W-1:0]   out_tag;

    pipelined_addsub #(.WIDTH(WIDTH), .STAGES(STAGES), .TAG_W(TAG_W)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .op(op), .in_tag(in_tag),
        .out_valid(out_valid), .out_ready(out_ready), .result(result),
        .carry(carry), .overflow(overflow), .zero(zero), .negative(negative),
        .out_tag(out_tag)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [WIDTH-1:0] res;
        logic             c, v, z, n;
        logic [TAG_W-1:0] tag;
        int               cyc;
    } exp_t;

    exp_t q[$];
    int   errors = 0;
    int   checks = 0;
    int   cyc = 0;
    int   stall_cnt = 0;
    int   stall_seen = 0;
    bit   rand_ready = 0;
    bit   strict = 1;

    // Reference: unsigned and signed arithmetic on 64-bit integers.
    function automatic exp_t model(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y,
                                   input logic o, input logic [TAG_W-1:0] t);
        exp_t   e;
        longint ux, uy, sx, sy, s, full, maxs, mins;
        ux = longint'(x);
        uy = longint'(y);
        sx = ux;
        sy = uy;
        if (x[WIDTH-1]) sx = sx - (longint'(1) << WIDTH);
        if (y[WIDTH-1]) sy = sy - (longint'(1) << WIDTH);
        maxs = (longint'(1) << (WIDTH-1)) - 1;
        mins = -(longint'(1) << (WIDTH-1));
        if (!o) begin
            full = ux + uy;
            e.c  = (full >= (longint'(1) << WIDTH));
            s    = sx + sy;
        end else begin
            full = ux - uy;
            e.c  = (ux >= uy);
            s    = sx - sy;
        end
        e.res = full[WIDTH-1:0];
        e.v   = (s > maxs) || (s < mins);
        e.z   = (e.res == '0);
        e.n   = e.res[WIDTH-1];
        e.tag = t;
        e.cyc = cyc;
        return e;
    endfunction

    function automatic logic [WIDTH-1:0] rnd();
        logic [WIDTH-1:0] one;
        logic [WIDTH-1:0] msb;
        one = 1;
        msb = one << (WIDTH-1);
        case ($urandom_range(0, 5))
            0:       return '0;
            1:       return '1;
            2:       return msb;
            3:       return msb - one;
            default: return WIDTH'($urandom);
        endcase
    endfunction

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // Consumer: out_ready is driven 2 time units after each rising edge.
    initial begin
        out_ready = 1'b1;
        forever begin
            @(posedge clk);
            #2;
            if (stall_cnt > 0) begin
                out_ready = 1'b0;
                stall_cnt--;
            end else if (rand_ready) begin
                out_ready = ($urandom_range(0, 3) != 0);
            end else begin
                out_ready = 1'b1;
            end
        end
    end

    // Monitor: samples on the falling edge, between input changes and the next accept edge.
    initial begin : monitor
        logic [WIDTH+TAG_W+4:0] snap;
        logic [WIDTH+TAG_W+4:0] now;
        bit   prev_stall;
        exp_t e;
        int   lat;
        prev_stall = 0;
        snap = '0;
        forever begin
            @(negedge clk);
            now = {result, carry, overflow, zero, negative, out_tag, out_valid};
            if (rst_n) begin
                if (prev_stall) begin
                    checks++;
                    if (now !== snap) begin
                        errors++;
                        $display("FAIL frozen_outputs: got %h, want %h", now, snap);
                    end
                end
                if (out_valid && !out_ready) begin
                    checks++;
                    stall_seen++;
                    if (in_ready !== 1'b0) begin
                        errors++;
                        $display("FAIL stall_in_ready: got %b, want 0", in_ready);
                    end
                end
                if (in_valid && in_ready) q.push_back(model(a, b, op, in_tag));
                if (out_valid && out_ready) begin
                    checks++;
                    if (q.size() == 0) begin
                        errors++;
                        $display("FAIL spurious_output: got res=%h tag=%0d, want no output", result, out_tag);
                    end else begin
                        e = q.pop_front();
                        if ({result, carry, overflow, zero, negative, out_tag} !==
                            {e.res, e.c, e.v, e.z, e.n, e.tag}) begin
                            errors++;
                            $display("FAIL result: got res=%h c=%b v=%b z=%b n=%b tag=%0d, want res=%h c=%b v=%b z=%b n=%b tag=%0d",
                                     result, carry, overflow, zero, negative, out_tag,
                                     e.res, e.c, e.v, e.z, e.n, e.tag);
                        end
                        lat = cyc - e.cyc;
                        checks++;
                        if (strict ? (lat != STAGES) : (lat < STAGES)) begin
                            errors++;
                            $display("FAIL latency: got %0d, want %0d", lat, STAGES);
                        end
                    end
                end
                prev_stall = out_valid && !out_ready;
                snap = now;
            end else begin
                prev_stall = 0;
            end
        end
    end

    // Called just after a rising edge; returns just after the edge that accepted the op.
    task automatic send(input logic [WIDTH-1:0] ta, input logic [WIDTH-1:0] tb_v,
                        input logic top, input logic [TAG_W-1:0] tt);
        int n;
        n = 0;
        a = ta;
        b = tb_v;
        op = top;
        in_tag = tt;
        in_valid = 1'b1;
        @(negedge clk);
        while (!in_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) begin
            checks++;
            errors++;
            $display("FAIL send_timeout: got in_ready=0 for %0d cycles, want 1", n);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        int n;
        n = 0;
        in_valid = 1'b0;
        while ((q.size() != 0 || out_valid) && n < 500) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL drain: got %0d results outstanding, want 0", q.size());
        end
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset_state(input string name);
        checks++;
        if ({out_valid, result, carry, overflow, zero, negative, out_tag, in_ready} !==
            {1'b0, {WIDTH{1'b0}}, 4'b0000, {TAG_W{1'b0}}, 1'b1}) begin
            errors++;
            $display("FAIL %s: got valid=%b res=%h c=%b v=%b z=%b n=%b tag=%0d in_ready=%b, want all 0 and in_ready=1",
                     name, out_valid, result, carry, overflow, zero, negative, out_tag, in_ready);
        end
    endtask

    logic [31:0] dir_a  [6] = '{32'h7FFFFFFF, 32'hFFFFFFFF, 32'h00FFFFFF, 32'd5, 32'd0, 32'h80000000};
    logic [31:0] dir_b  [6] = '{32'h1, 32'h1, 32'h1, 32'd5, 32'd1, 32'h1};
    logic        dir_op [6] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};

    initial begin
        int seen0;
        rst_n = 1'b0;
        in_valid = 1'b0;
        a = '0;
        b = '0;
        op = 1'b0;
        in_tag = '0;
        repeat (3) @(posedge clk);
        #1;
        check_reset_state("reset_state");
        rst_n = 1'b1;

        // Directed vectors, one at a time: exact latency.
        strict = 1;
        for (int i = 0; i < 6; i++) begin
            send(WIDTH'(dir_a[i]), WIDTH'(dir_b[i]), dir_op[i], TAG_W'(i));
            drain();
        end
        // Same vectors back-to-back.
        for (int i = 0; i < 6; i++) send(WIDTH'(dir_a[i]), WIDTH'(dir_b[i]), dir_op[i], TAG_W'(i + 8));
        drain();

        // Backpressure mid-stream.
        strict = 0;
        seen0 = stall_seen;
        for (int i = 0; i < 8; i++) begin
            send(rnd(), rnd(), 1'($urandom), TAG_W'(i));
            if (i == 3) stall_cnt = 3;
        end
        drain();
        checks++;
        if (stall_seen - seen0 < 3) begin
            errors++;
            $display("FAIL stall_observed: got %0d stalled cycles, want >= 3", stall_seen - seen0);
        end

        // Reset with operations in flight.
        strict = 1;
        for (int i = 0; i < 3; i++) send(WIDTH'(100 + i), WIDTH'(7), 1'b0, TAG_W'(20 + i));
        rst_n = 1'b0;
        in_valid = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        q.delete();
        check_reset_state("post_reset");
        send(WIDTH'(3), WIDTH'(9), 1'b1, TAG_W'(30));
        drain();

        // Random traffic with random gaps and random backpressure.
        strict = 0;
        rand_ready = 1;
        for (int i = 0; i < 2000; i++) begin
            if ($urandom_range(0, 3) == 0) begin
                in_valid = 1'b0;
                a = rnd();
                @(posedge clk);
                #1;
            end
            send(rnd(), rnd(), 1'($urandom), TAG_W'($urandom));
        end
        rand_ready = 0;
        drain();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/pipelined_addsub.md
Name: pipelined_addsub

Overview:
- Parametrised, pipelined two's-complement adder/subtractor; successor to the single-cycle combinational ALU adder.
- Splits the carry chain into STAGES segments, one segment per pipeline stage, so wide operands close timing.
- Returns result plus the full flag set: carry, signed overflow, zero and negative.
- Ready/valid handshake on both sides; an optional tag travels with each operation. Sits between the ALU operand mux and writeback.

Parameters:
WIDTH, 32, operand/result width in bits; must be a multiple of STAGES
STAGES, 4, pipeline depth and carry-chain segment count (1..WIDTH); segment width SEG = WIDTH/STAGES
TAG_W, 5, width of the pass-through tag (e.g. destination register index)

Ports:
clk  in  1  clock; all logic on the rising edge
rst_n  in  1  synchronous, active-low reset
in_valid  in  1  operation offered
in_ready  out  1  block accepts an operation this cycle
a  in  WIDTH  operand A
b  in  WIDTH  operand B
op  in  1  0 = A+B, 1 = A-B
in_tag  in  TAG_W  user tag, returned unchanged
out_valid  out  1  result available
out_ready  in  1  consumer accepts the result
result  out  WIDTH  sum/difference modulo 2^WIDTH
carry  out  1  carry out of the MSB; for subtraction 1 = no borrow (A >= B unsigned)
overflow  out  1  signed overflow = carry into MSB XOR carry out of MSB
zero  out  1  result == 0
negative  out  1  result[WIDTH-1]
out_tag  out  TAG_W  tag of the operation on result

Behaviour:
- Subtraction is computed as A + ~B + 1; the +1 is the carry-in to segment 0. Addition uses carry-in 0.
- Stage k (0..STAGES-1):
  - adds bits [k*SEG +: SEG] of A and B' (B or ~B), plus the carry registered from stage k-1 (stage 0: op).
  - registers the partial sum and carry-out.
  - carries forward the not-yet-used upper operand bits, op and tag.
- The last stage also registers carry, overflow, zero and negative. Overflow uses the carry into bit WIDTH-1, taken inside the last segment.
- Global advance: adv = ~out_valid | out_ready. All stage registers, including per-stage valid bits, load only when adv = 1. in_ready = adv (combinational).
- Accept: an operation is accepted when in_valid & in_ready. A stage-0 valid bit is 0 when no operation is accepted, so bubbles propagate and are not collapsed.
- Latency: exactly STAGES cycles from accept to out_valid when out_ready stays high. Throughput: 1 op/cycle.
- Backpressure: while out_valid & ~out_ready, the whole pipe freezes. Outputs hold stable and in_ready = 0; no operation is lost, duplicated or reordered.
- out_valid, result, flags and out_tag change only on cycles where adv = 1.
- Reset (rst_n = 0 at a clock edge):
  - all valid bits clear; out_valid = 0; result, carry, overflow, zero, negative and out_tag = 0.
  - in-flight operations are discarded, including mid-pipeline.
  - in_ready = 1 the cycle after reset.
- in_ready is not forced low while in reset; inputs sampled during reset are discarded.
- Simultaneous output accept and input accept in the same cycle is legal and sustains full throughput.
- STAGES = 1 degenerates to a single registered add/sub with latency 1.
- Operands and op are sampled only on accept; changes on the inputs while not accepted have no effect.

Test Plan:
- Add, signed overflow: a=0x7FFFFFFF, b=0x00000001, op=0 -> result 0x80000000, carry 0, overflow 1, negative 1, zero 0, after exactly 4 cycles.
- Add, unsigned wrap and inter-segment carry ripple: a=0xFFFFFFFF, b=1, op=0 -> result 0x00000000, carry 1, overflow 0, zero 1. Also a=0x00FFFFFF, b=1 -> 0x01000000, carry 0.
- Subtract: a=5, b=5, op=1 -> 0, carry 1, zero 1. a=0, b=1, op=1 -> 0xFFFFFFFF, carry 0, overflow 0, negative 1. a=0x80000000, b=1, op=1 -> 0x7FFFFFFF, overflow 1.
- Backpressure: stream 8 ops with tags 0..7 back-to-back; hold out_ready=0 for 3 cycles mid-stream -> outputs frozen, in_ready=0 during the stall, all 8 results delivered in tag order with correct values and no duplicates.
- Reset mid-operation: accept 3 ops, assert rst_n=0 for one edge -> out_valid=0 and all outputs 0 next cycle; none of the 3 results ever appear. A new op after reset completes in 4 cycles.
- Parameter sweep: WIDTH=32 with STAGES=1, 2, 8; WIDTH=16 with STAGES=4; 10k random ops per configuration against a reference model (A±B modulo 2^WIDTH, flag equations above) -> zero mismatches; latency equals STAGES.
